// File: rtl/kbd_seq_if.sv
// Bundle between the keyboard character sequencer and its neighbours:
// PS/2 byte input, mapper drive, text-buffer write handshake and status.
interface kbd_seq_if #(
  parameter int COLS = 40,
  parameter int ROWS = 15
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          sc_valid;
  logic [7:0]    sc_data;
  logic [7:0]    map_scan_code;
  logic          map_letter_case;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic          caps_led;
  logic          drop;

  modport master (
    input  sc_valid, sc_data, wr_ready,
    output map_scan_code, map_letter_case, wr_valid, wr_col, wr_row, caps_led, drop
  );

  modport slave (
    output sc_valid, sc_data, wr_ready,
    input  map_scan_code, map_letter_case, wr_valid, wr_col, wr_row, caps_led, drop
  );
endinterface

// File: rtl/kbd_char_sequencer.sv
// PS/2 set-2 byte sequencer: prefix decode, Shift/Caps tracking, text cursor
// management and one valid/ready glyph write per printable key.
module kbd_char_sequencer #(
  parameter int COLS  = 40,
  parameter int ROWS  = 15,
  parameter int TAB_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  kbd_seq_if.master bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, EMIT} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          shift_l, shift_r, caps, caps_held, adv;
  logic          wr_valid_q, case_q, drop_q;
  logic [7:0]    code_q;
  logic [CW-1:0] wr_col_q;
  logic [RW-1:0] wr_row_q;

  logic [CW:0]   tab_col;
  logic [CW-1:0] bs_col;
  logic [RW-1:0] bs_row;
  logic          bs_ok;
  logic          cur_case;

  function automatic logic is_printable(input logic [7:0] b);
    case (b)
      8'h0E, 8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E,
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h29,
      8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E,
      8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
      8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E,
      8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
      8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E,
      8'h52, 8'h54, 8'h55, 8'h5B, 8'h5D: is_printable = 1'b1;
      default:                           is_printable = 1'b0;
    endcase
  endfunction

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    row_inc = (r == LAST_ROW) ? '0 : r + RW'(1);
  endfunction

  // One extra bit so a tab stop past the last column is visible as overflow.
  function automatic logic [CW:0] tab_next(input logic [CW-1:0] c);
    tab_next = (({1'b0, c} / (CW+1)'(TAB_W)) + (CW+1)'(1)) * (CW+1)'(TAB_W);
  endfunction

  assign tab_col  = tab_next(col);
  assign bs_ok    = (col != '0) || (row != '0);
  assign bs_col   = (col != '0) ? col - CW'(1) : LAST_COL;
  assign bs_row   = (col != '0) ? row : row - RW'(1);
  assign cur_case = (shift_l | shift_r) ^ caps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      caps       <= 1'b0;
      caps_held  <= 1'b0;
      adv        <= 1'b0;
      wr_valid_q <= 1'b0;
      case_q     <= 1'b0;
      drop_q     <= 1'b0;
      code_q     <= '0;
      wr_col_q   <= '0;
      wr_row_q   <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: if (bus.sc_valid) begin
          case (bus.sc_data)
            8'hF0: state   <= BRK;
            8'hE0: state   <= EXT;
            8'h12: shift_l <= 1'b1;
            8'h59: shift_r <= 1'b1;
            8'h58: begin
              if (!caps_held) caps <= ~caps;
              caps_held <= 1'b1;
            end
            8'h5A: begin
              col <= '0;
              row <= row_inc(row);
            end
            8'h0D: begin
              if (tab_col >= (CW+1)'(COLS)) begin
                col <= '0;
                row <= row_inc(row);
              end else begin
                col <= tab_col[CW-1:0];
              end
            end
            // Backspace moves first, then blanks the cell it landed on.
            8'h66: if (bs_ok) begin
              col        <= bs_col;
              row        <= bs_row;
              code_q     <= 8'h29;
              wr_col_q   <= bs_col;
              wr_row_q   <= bs_row;
              case_q     <= cur_case;
              adv        <= 1'b0;
              wr_valid_q <= 1'b1;
              state      <= EMIT;
            end
            default: if (is_printable(bus.sc_data)) begin
              code_q     <= bus.sc_data;
              wr_col_q   <= col;
              wr_row_q   <= row;
              case_q     <= cur_case;
              adv        <= 1'b1;
              wr_valid_q <= 1'b1;
              state      <= EMIT;
            end
          endcase
        end
        BRK: if (bus.sc_valid) begin
          case (bus.sc_data)
            8'h12:   shift_l   <= 1'b0;
            8'h59:   shift_r   <= 1'b0;
            8'h58:   caps_held <= 1'b0;
            default: ;
          endcase
          state <= IDLE;
        end
        EXT: if (bus.sc_valid) state <= (bus.sc_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: if (bus.sc_valid) state <= IDLE;
        EMIT: begin
          if (bus.sc_valid) drop_q <= 1'b1;
          if (bus.wr_ready) begin
            wr_valid_q <= 1'b0;
            state      <= IDLE;
            if (adv) begin
              if (col == LAST_COL) begin
                col <= '0;
                row <= row_inc(row);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_valid        = wr_valid_q;
  assign bus.map_scan_code   = code_q;
  assign bus.map_letter_case = case_q;
  assign bus.wr_col          = wr_col_q;
  assign bus.wr_row          = wr_row_q;
  assign bus.caps_led        = caps;
  assign bus.drop            = drop_q;
endmodule

// File: tb/tb_kbd_char_sequencer.sv
// Directed bench for kbd_char_sequencer: a vector table for byte sequences
// plus hand-written cursor-wrap, busy-drop and reset-in-EMIT sequences.
module tb_kbd_char_sequencer;
  localparam int COLS = 40;
  localparam int ROWS = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kbd_seq_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  kbd_char_sequencer #(.COLS(COLS), .ROWS(ROWS), .TAB_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] sc;
    bit         w;
    logic [7:0] code;
    bit         cs;
    int         col;
    int         row;
    bit         caps;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t v(input logic [7:0] sc, input bit w, input logic [7:0] code,
                             input bit cs, input int col, input int row, input bit caps);
    vec_t r;
    r.sc = sc; r.w = w; r.code = code; r.cs = cs; r.col = col; r.row = row; r.caps = caps;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.sc_valid = 1'b1;
    bus.sc_data  = b;
    @(negedge clk);
    bus.sc_valid = 1'b0;
  endtask

  // Send a byte with wr_ready=1 and check whether exactly one write results.
  task automatic key(input string name, input logic [7:0] b, input bit w,
                     input logic [7:0] code, input bit cs, input int col, input int row);
    send(b);
    chk({name, ".valid"}, bus.wr_valid, w);
    if (w) begin
      chk({name, ".code"}, bus.map_scan_code, code);
      chk({name, ".case"}, bus.map_letter_case, cs);
      chk({name, ".col"}, bus.wr_col, col);
      chk({name, ".row"}, bus.wr_row, row);
    end
    @(negedge clk);
    chk({name, ".done"}, bus.wr_valid, 1'b0);
  endtask

  task automatic fill(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      send(b);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sc_valid = 1'b0;
    bus.sc_data  = 8'h00;
    bus.wr_ready = 1'b1;

    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  0, 0, 0));
    tbl.push_back(v(8'h12, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 1,  1, 0, 0));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h1C, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h12, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  2, 0, 0));
    tbl.push_back(v(8'h58, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h58, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h58, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 1,  3, 0, 1));
    tbl.push_back(v(8'h12, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  4, 0, 1));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h12, 0, 8'h00, 0,  0, 0, 1));
    tbl.push_back(v(8'h58, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h58, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h66, 1, 8'h29, 0,  4, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  4, 0, 0));
    tbl.push_back(v(8'h0D, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  8, 0, 0));
    tbl.push_back(v(8'h5A, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h66, 1, 8'h29, 0, 39, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0, 39, 0, 0));
    tbl.push_back(v(8'hE0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h75, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'hE0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h75, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h1C, 1, 8'h1C, 0,  0, 1, 0));
    tbl.push_back(v(8'h76, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h29, 1, 8'h29, 0,  1, 1, 0));
    tbl.push_back(v(8'h0D, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h0E, 1, 8'h0E, 0,  4, 1, 0));
    tbl.push_back(v(8'h59, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h15, 1, 8'h15, 1,  5, 1, 0));
    tbl.push_back(v(8'hF0, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h59, 0, 8'h00, 0,  0, 0, 0));
    tbl.push_back(v(8'h15, 1, 8'h15, 0,  6, 1, 0));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.wr_valid", bus.wr_valid, 1'b0);
    chk("rst.code", bus.map_scan_code, 8'h00);
    chk("rst.case", bus.map_letter_case, 1'b0);
    chk("rst.col", bus.wr_col, 0);
    chk("rst.row", bus.wr_row, 0);
    chk("rst.caps_led", bus.caps_led, 1'b0);
    chk("rst.drop", bus.drop, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      key($sformatf("vec%0d", i), tbl[i].sc, tbl[i].w, tbl[i].code, tbl[i].cs,
          tbl[i].col, tbl[i].row);
      chk($sformatf("vec%0d.caps_led", i), bus.caps_led, tbl[i].caps);
    end

    // Cursor wrap at end of row and end of screen
    do_reset();
    fill(8'h5A, 3);
    fill(8'h1C, COLS - 1);
    key("wrap.lastcol", 8'h1C, 1, 8'h1C, 0, COLS - 1, 3);
    key("wrap.nextrow", 8'h1C, 1, 8'h1C, 0, 0, 4);
    fill(8'h5A, 10);
    fill(8'h1C, COLS - 1);
    key("wrap.lastcell", 8'h1C, 1, 8'h1C, 0, COLS - 1, ROWS - 1);
    key("wrap.bs_origin", 8'h66, 0, 8'h00, 0, 0, 0);
    key("wrap.home", 8'h1C, 1, 8'h1C, 0, 0, 0);
    fill(8'h1C, 37);
    key("tab38", 8'h0D, 0, 8'h00, 0, 0, 0);
    key("tab38.after", 8'h1C, 1, 8'h1C, 0, 0, 1);
    key("bs.enter", 8'h5A, 0, 8'h00, 0, 0, 0);
    key("bs.row_up", 8'h66, 1, 8'h29, 0, COLS - 1, 1);
    key("bs.stay", 8'h1C, 1, 8'h1C, 0, COLS - 1, 1);

    // Busy: bytes during EMIT are dropped, including on the transfer cycle
    bus.wr_ready = 1'b0;
    send(8'h1C);
    chk("busy.valid", bus.wr_valid, 1'b1);
    chk("busy.col", bus.wr_col, 0);
    chk("busy.row", bus.wr_row, 2);
    send(8'h1C);
    chk("busy.drop", bus.drop, 1'b1);
    chk("busy.hold_valid", bus.wr_valid, 1'b1);
    chk("busy.hold_col", bus.wr_col, 0);
    @(negedge clk);
    chk("busy.drop_pulse", bus.drop, 1'b0);
    chk("busy.still_valid", bus.wr_valid, 1'b1);
    bus.wr_ready = 1'b1;
    bus.sc_valid = 1'b1;
    bus.sc_data  = 8'h1C;
    @(negedge clk);
    bus.sc_valid = 1'b0;
    chk("busy.xfer_drop", bus.drop, 1'b1);
    chk("busy.xfer_done", bus.wr_valid, 1'b0);
    @(negedge clk);
    chk("busy.no_second", bus.wr_valid, 1'b0);
    key("busy.next", 8'h1C, 1, 8'h1C, 0, 1, 2);

    // Asynchronous reset while a write is pending
    bus.wr_ready = 1'b0;
    send(8'h1C);
    chk("rstemit.valid", bus.wr_valid, 1'b1);
    chk("rstemit.col", bus.wr_col, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstemit.cleared", bus.wr_valid, 1'b0);
    chk("rstemit.col0", bus.wr_col, 0);
    chk("rstemit.row0", bus.wr_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    key("rstemit.home", 8'h1C, 1, 8'h1C, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
